// File: rtl/gpu_sram_write_ctrl.sv
// Frame-buffer SRAM write-port controller.
// Pixels (address + colour) from the rasteriser are queued in a small FIFO and
// written to the SRAM with a SETUP / STROBE / HOLD sequence on the chip strobes.
// Back-to-back pixels keep the chip enabled; a long idle period puts the SRAM
// into sleep (ZZ) and the next pixel wakes it with one extra cycle.
//
// state   | meaning
// --------+----------------------------------------------------------------
// IDLE    | chip deselected, counting idle cycles towards sleep
// SLEEP   | chip deselected, ZZ asserted
// WAKE    | ZZ released, one settling cycle before the write
// SETUP   | chip selected, address/data presented, R_W high
// STROBE  | R_W low for WAIT_STATES+1 cycles
// HOLD    | R_W high, chip still selected; chains into the next pixel if queued
module gpu_sram_write_ctrl #(
    parameter int CHANNEL_BITS = 8,
    parameter int NUM_CHANNELS = 3,
    parameter int ADDR_BITS    = 20,
    parameter int FIFO_DEPTH   = 8,
    parameter int WAIT_STATES  = 2,
    parameter int SLEEP_CYCLES = 16,
    localparam int RGB_W = CHANNEL_BITS * NUM_CHANNELS
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 pix_valid_i,
    output logic                 pix_ready_o,
    input  logic [ADDR_BITS-1:0] pix_addr_i,
    input  logic [RGB_W-1:0]     pix_rgb_i,
    output logic                 busy_o,
    output logic [31:0]          write_count_o,
    output logic                 CE0_o,
    output logic                 CE1_o,
    output logic                 R_W_o,
    output logic                 OE_o,
    output logic                 LB_o,
    output logic                 UB_o,
    output logic                 ZZ_o,
    output logic                 SEM_o,
    output logic [ADDR_BITS-1:0] adddataout_o,
    output logic [RGB_W-1:0]     rgbdataout_o
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int IDLE_W = (SLEEP_CYCLES > 1) ? $clog2(SLEEP_CYCLES) : 1;
    localparam bit SLEEP_EN = (SLEEP_CYCLES != 0);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'((SLEEP_CYCLES > 0) ? SLEEP_CYCLES - 1 : 0);
    localparam logic [3:0]        WAIT_LOAD = 4'(WAIT_STATES);
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAKE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_SLEEP
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_BITS+RGB_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]           wr_ptr, rd_ptr;
    logic [CNT_W-1:0]           fifo_cnt, fifo_cnt_nxt;
    logic                       fifo_empty;
    logic                       push, pop;
    logic [ADDR_BITS-1:0]       head_addr;
    logic [RGB_W-1:0]           head_rgb;

    logic [3:0]        wait_cnt, wait_nxt;
    logic [IDLE_W-1:0] idle_cnt, idle_nxt;
    logic              strobe_done;
    logic              ce_act_d, r_w_d, zz_d, busy_d;

    assign push       = pix_valid_i & pix_ready_o;
    assign fifo_empty = (fifo_cnt == '0);
    assign {head_addr, head_rgb} = fifo_mem[rd_ptr];

    // Write-only port: output enable and semaphore select are never used.
    assign OE_o  = 1'b1;
    assign SEM_o = 1'b1;

    // Occupancy after this cycle's push/pop.
    always_comb begin
        fifo_cnt_nxt = fifo_cnt;
        case ({push, pop})
            2'b10:   fifo_cnt_nxt = fifo_cnt + CNT_W'(1);
            2'b01:   fifo_cnt_nxt = fifo_cnt - CNT_W'(1);
            default: fifo_cnt_nxt = fifo_cnt;
        endcase
    end

    // Pixel storage; contents need no reset since occupancy guards every read.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {pix_addr_i, pix_rgb_i};
        end
    end

    // FIFO pointers, occupancy and registered ready (low while full, even if popping).
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_cnt    <= '0;
            pix_ready_o <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            fifo_cnt    <= fifo_cnt_nxt;
            pix_ready_o <= (fifo_cnt_nxt != FULL_CNT);
        end
    end

    // State register with the wait-state and idle counters.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
            idle_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            idle_cnt <= idle_nxt;
        end
    end

    // Next-state logic, FIFO pop decision and counter updates.
    always_comb begin
        state_nxt   = state;
        pop         = 1'b0;
        wait_nxt    = wait_cnt;
        idle_nxt    = '0;
        strobe_done = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = ST_SETUP;
                end else if (push) begin
                    idle_nxt = '0;
                end else if (SLEEP_EN && (idle_cnt == IDLE_LAST)) begin
                    state_nxt = ST_SLEEP;
                end else begin
                    idle_nxt = idle_cnt + IDLE_W'(1);
                end
            end
            ST_SLEEP: begin
                if (!fifo_empty) state_nxt = ST_WAKE;
            end
            ST_WAKE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = ST_SETUP;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_SETUP: begin
                state_nxt = ST_STROBE;
                wait_nxt  = WAIT_LOAD;
            end
            ST_STROBE: begin
                if (wait_cnt == '0) begin
                    state_nxt   = ST_HOLD;
                    strobe_done = 1'b1;
                end else begin
                    wait_nxt = wait_cnt - 4'd1;
                end
            end
            ST_HOLD: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = ST_SETUP;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Strobe levels for the state being entered, so every pin comes out of a flop.
    always_comb begin
        ce_act_d = 1'b0;
        r_w_d    = 1'b1;
        zz_d     = 1'b0;
        case (state_nxt)
            ST_SETUP, ST_HOLD: ce_act_d = 1'b1;
            ST_STROBE: begin
                ce_act_d = 1'b1;
                r_w_d    = 1'b0;
            end
            ST_SLEEP: zz_d = 1'b1;
            default: ;
        endcase
        busy_d = !(((state_nxt == ST_IDLE) || (state_nxt == ST_SLEEP)) && (fifo_cnt_nxt == '0));
    end

    // Registered SRAM pins, address/data capture on pop, and the write counter.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            CE0_o         <= 1'b1;
            CE1_o         <= 1'b0;
            R_W_o         <= 1'b1;
            LB_o          <= 1'b1;
            UB_o          <= 1'b1;
            ZZ_o          <= 1'b0;
            busy_o        <= 1'b0;
            adddataout_o  <= '0;
            rgbdataout_o  <= '0;
            write_count_o <= '0;
        end else begin
            CE0_o  <= !ce_act_d;
            CE1_o  <= ce_act_d;
            R_W_o  <= r_w_d;
            LB_o   <= !ce_act_d;
            UB_o   <= !ce_act_d;
            ZZ_o   <= zz_d;
            busy_o <= busy_d;
            if (pop) begin
                adddataout_o <= head_addr;
                rgbdataout_o <= head_rgb;
            end
            if (strobe_done) write_count_o <= write_count_o + 32'd1;
        end
    end

endmodule
